adma_event_responder: RTL and testbench

Host-register-side responder for the ADMA engine's event handshakes in the SD Host. It answers the engine's four request/acknowledge channels (DMA interrupt, ADMA error, transfer complete, system-address update). It latches each event into sticky write-1-to-clear status bits, captures error and address payloads, and drives the combined host interrupt. It also holds the host-programmed Initial ADMA System Address that feeds the engine.

---
 rtl/adma_event_responder.sv | 122 ++++++++++++
 tb/tb_adma_event_responder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/adma_event_responder.sv
// adma_event_responder: host-register-side responder for the ADMA engine's
// four-phase event handshakes. It keeps sticky write-1-to-clear status,
// captures the error and system-address payloads, and drives the host irq.
//
// Per-channel handshake FSM (one instance per request channel):
//   state   | meaning
//   IDLE    | ack low; waiting for the request to be sampled high
//   ACK     | ack high; event taken, waiting for the request to drop
//
// Channel index matches int_status bit:
//   0 Transfer_complete, 1 DMA_Interrupt, 2 ADMA_Error, 3 ADMA_System_Address_Register
module adma_event_responder #(
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              DMA_Interrupt,
  input  logic              ADMA_Error,
  input  logic              Transfer_complete,
  input  logic              ADMA_System_Address_Register,
  input  logic [1:0]        adma_err_state_in,
  input  logic              adma_len_mismatch_in,
  input  logic [ADDR_W-1:0] dma_sys_addr_in,
  output logic              ack_DMA_Interrupt,
  output logic              ack_ADMA_Error,
  output logic              ack_Transfer_complete,
  output logic              ack_ADMA_System_Address_Register,
  input  logic              host_addr_wr,
  input  logic [ADDR_W-1:0] host_addr_wdata,
  input  logic [3:0]        status_clr,
  input  logic [3:0]        sig_en,
  output logic [ADDR_W-1:0] Initial_ADMA_System_Address,
  output logic [ADDR_W-1:0] sys_addr_q,
  output logic [3:0]        int_status,
  output logic [1:0]        adma_err_state,
  output logic              adma_len_mismatch,
  output logic              irq
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACK  = 1'b1;

  logic [3:0] req;
  logic [3:0] ack;
  logic [3:0] set_evt;

  assign req = {ADMA_System_Address_Register, ADMA_Error, DMA_Interrupt, Transfer_complete};

  for (genvar g = 0; g < 4; g++) begin : g_ch
    logic [0:0] state_q;

    // Four-phase handshake: one event per high phase of the request.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state_q <= ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: if (req[g])  state_q <= ST_ACK;
          ST_ACK:  if (!req[g]) state_q <= ST_IDLE;
          default: state_q <= ST_IDLE;
        endcase
      end
    end

    assign ack[g]     = (state_q == ST_ACK);
    assign set_evt[g] = (state_q == ST_IDLE) && req[g];
  end

  assign ack_Transfer_complete            = ack[0];
  assign ack_DMA_Interrupt                = ack[1];
  assign ack_ADMA_Error                   = ack[2];
  assign ack_ADMA_System_Address_Register = ack[3];

  // Sticky status: a new event beats a same-cycle host clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      int_status <= 4'b0000;
    end else begin
      int_status <= (int_status & ~status_clr) | set_evt;
    end
  end

  // Error payload: first error is held until the host clears status bit 2.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      adma_err_state    <= 2'b00;
      adma_len_mismatch <= 1'b0;
    end else if (set_evt[2] && !int_status[2]) begin
      adma_err_state    <= adma_err_state_in;
      adma_len_mismatch <= adma_len_mismatch_in;
    end else if (status_clr[2] && !set_evt[2]) begin
      adma_err_state    <= 2'b00;
      adma_len_mismatch <= 1'b0;
    end
  end

  // Host-programmed start address; also seeds the readable system address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      Initial_ADMA_System_Address <= '0;
    end else if (host_addr_wr) begin
      Initial_ADMA_System_Address <= host_addr_wdata;
    end
  end

  // Engine address updates take priority over a same-cycle host write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sys_addr_q <= '0;
    end else if (set_evt[3]) begin
      sys_addr_q <= dma_sys_addr_in;
    end else if (host_addr_wr) begin
      sys_addr_q <= host_addr_wdata;
    end
  end

  // Interrupt follows sig_en immediately; no latching.
  always_comb begin
    irq = |(int_status & sig_en);
  end

endmodule

// File: tb/tb_adma_event_responder.sv
// Self-checking bench for adma_event_responder: a behavioural reference
// model pushes expected outputs each cycle; they are popped and compared
// one cycle later, plus directed checks for the called-out scenarios.
module tb_adma_event_responder;

  localparam int ADDR_W = 64;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              DMA_Interrupt, ADMA_Error, Transfer_complete, ADMA_System_Address_Register;
  logic [1:0]        adma_err_state_in;
  logic              adma_len_mismatch_in;
  logic [ADDR_W-1:0] dma_sys_addr_in;
  logic              ack_DMA_Interrupt, ack_ADMA_Error, ack_Transfer_complete, ack_ADMA_System_Address_Register;
  logic              host_addr_wr;
  logic [ADDR_W-1:0] host_addr_wdata;
  logic [3:0]        status_clr, sig_en;
  logic [ADDR_W-1:0] Initial_ADMA_System_Address, sys_addr_q;
  logic [3:0]        int_status;
  logic [1:0]        adma_err_state;
  logic              adma_len_mismatch, irq;

  adma_event_responder #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .DMA_Interrupt(DMA_Interrupt), .ADMA_Error(ADMA_Error),
    .Transfer_complete(Transfer_complete),
    .ADMA_System_Address_Register(ADMA_System_Address_Register),
    .adma_err_state_in(adma_err_state_in), .adma_len_mismatch_in(adma_len_mismatch_in),
    .dma_sys_addr_in(dma_sys_addr_in),
    .ack_DMA_Interrupt(ack_DMA_Interrupt), .ack_ADMA_Error(ack_ADMA_Error),
    .ack_Transfer_complete(ack_Transfer_complete),
    .ack_ADMA_System_Address_Register(ack_ADMA_System_Address_Register),
    .host_addr_wr(host_addr_wr), .host_addr_wdata(host_addr_wdata),
    .status_clr(status_clr), .sig_en(sig_en),
    .Initial_ADMA_System_Address(Initial_ADMA_System_Address),
    .sys_addr_q(sys_addr_q), .int_status(int_status),
    .adma_err_state(adma_err_state), .adma_len_mismatch(adma_len_mismatch),
    .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]        ack;
    logic [3:0]        st;
    logic [1:0]        es;
    logic              lm;
    logic              irq;
    logic [ADDR_W-1:0] sys;
    logic [ADDR_W-1:0] init;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [3:0]        m_ack, m_st;
  logic [1:0]        m_es;
  logic              m_lm;
  logic [ADDR_W-1:0] m_sys, m_init;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ack = '0; m_st = '0; m_es = '0; m_lm = 1'b0; m_sys = '0; m_init = '0;
  endtask

  function automatic logic [3:0] dut_ack();
    return {ack_ADMA_System_Address_Register, ack_ADMA_Error, ack_DMA_Interrupt, ack_Transfer_complete};
  endfunction

  // Advance the model on the current inputs, push expectation, clock, compare.
  task automatic tick();
    logic [3:0] req, evt;
    exp_t e, o;
    req = {ADMA_System_Address_Register, ADMA_Error, DMA_Interrupt, Transfer_complete};
    evt = req & ~m_ack;
    if (evt[2] && !m_st[2]) begin
      m_es = adma_err_state_in; m_lm = adma_len_mismatch_in;
    end else if (status_clr[2] && !evt[2]) begin
      m_es = 2'b00; m_lm = 1'b0;
    end
    m_st = (m_st & ~status_clr) | evt;
    if (evt[3]) m_sys = dma_sys_addr_in;
    else if (host_addr_wr) m_sys = host_addr_wdata;
    if (host_addr_wr) m_init = host_addr_wdata;
    m_ack = req;
    e.ack = m_ack; e.st = m_st; e.es = m_es; e.lm = m_lm;
    e.irq = |(m_st & sig_en); e.sys = m_sys; e.init = m_init;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 64'd0, 64'd1);
    end else begin
      o = sb_q.pop_front();
      chk("sb_ack", 64'(dut_ack()), 64'(o.ack));
      chk("sb_status", 64'(int_status), 64'(o.st));
      chk("sb_err_state", 64'(adma_err_state), 64'(o.es));
      chk("sb_len_mm", 64'(adma_len_mismatch), 64'(o.lm));
      chk("sb_irq", 64'(irq), 64'(o.irq));
      chk("sb_sys_addr", sys_addr_q, o.sys);
      chk("sb_init_addr", Initial_ADMA_System_Address, o.init);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    DMA_Interrupt = 0; ADMA_Error = 0; Transfer_complete = 0; ADMA_System_Address_Register = 0;
    adma_err_state_in = '0; adma_len_mismatch_in = 0; dma_sys_addr_in = '0;
    host_addr_wr = 0; host_addr_wdata = '0; status_clr = '0; sig_en = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", 64'(dut_ack()), 64'd0);
    chk("rst_status", 64'(int_status), 64'd0);
    chk("rst_irq", 64'(irq), 64'd0);
    chk("rst_sys", sys_addr_q, 64'd0);
    reset_n = 1'b1;
    tick(); tick();

    // Transfer complete held 3 cycles
    Transfer_complete = 1;
    tick();
    chk("tc_ack_rise", 64'(ack_Transfer_complete), 64'd1);
    tick(); tick();
    chk("tc_ack_hold", 64'(ack_Transfer_complete), 64'd1);
    Transfer_complete = 0;
    tick();
    chk("tc_ack_fall", 64'(ack_Transfer_complete), 64'd0);
    chk("tc_status", 64'(int_status), 64'h1);
    chk("tc_irq_off", 64'(irq), 64'd0);
    sig_en = 4'b0001;
    #1;
    chk("tc_irq_on", 64'(irq), 64'd1);
    tick();

    // ADMA error: first error preserved, clear re-arms capture
    ADMA_Error = 1; adma_err_state_in = 2'b01; adma_len_mismatch_in = 1;
    tick();
    ADMA_Error = 0; tick();
    ADMA_Error = 1; adma_err_state_in = 2'b11; adma_len_mismatch_in = 0;
    tick();
    ADMA_Error = 0; tick();
    chk("err_first_kept", 64'(adma_err_state), 64'h1);
    chk("err_lm_kept", 64'(adma_len_mismatch), 64'h1);
    status_clr = 4'b0100; tick();
    status_clr = 4'b0000;
    chk("err_cleared", 64'(adma_err_state), 64'h0);
    ADMA_Error = 1; adma_err_state_in = 2'b10; tick();
    ADMA_Error = 0; tick();
    chk("err_recapture", 64'(adma_err_state), 64'h2);

    // Same-cycle DMA address capture and host write
    ADMA_System_Address_Register = 1; dma_sys_addr_in = 64'h0000_0001_2345_6780;
    host_addr_wr = 1; host_addr_wdata = 64'hAAAA;
    tick();
    host_addr_wr = 0; ADMA_System_Address_Register = 0;
    chk("addr_sys", sys_addr_q, 64'h0000_0001_2345_6780);
    chk("addr_init", Initial_ADMA_System_Address, 64'hAAAA);
    chk("addr_status", 64'(int_status[3]), 64'd1);
    tick();

    // Host clear collides with DMA interrupt set
    status_clr = 4'b0010; DMA_Interrupt = 1; tick();
    status_clr = 4'b0000;
    chk("clr_vs_set", 64'(int_status[1]), 64'd1);
    DMA_Interrupt = 0; tick();

    // All four channels together
    status_clr = 4'hF; tick();
    status_clr = 4'h0;
    {ADMA_System_Address_Register, ADMA_Error, DMA_Interrupt, Transfer_complete} = 4'hF;
    dma_sys_addr_in = 64'h1234; tick();
    chk("all_ack", 64'(dut_ack()), 64'hF);
    chk("all_status", 64'(int_status), 64'hF);
    {ADMA_System_Address_Register, ADMA_Error, DMA_Interrupt, Transfer_complete} = 4'h0;
    tick();

    // Reset mid-handshake
    status_clr = 4'hF; tick();
    status_clr = 4'h0;
    DMA_Interrupt = 1; tick(); tick();
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid_ack", 64'(ack_DMA_Interrupt), 64'd0);
    model_reset();
    @(posedge clk); #1;
    reset_n = 1'b1;
    tick();
    chk("rst_new_ack", 64'(ack_DMA_Interrupt), 64'd1);
    chk("rst_new_status", 64'(int_status[1]), 64'd1);
    DMA_Interrupt = 0; tick();

    // Random traffic against the model
    for (int i = 0; i < 300; i++) begin
      {ADMA_System_Address_Register, ADMA_Error, DMA_Interrupt, Transfer_complete} = 4'($urandom_range(0, 15));
      adma_err_state_in    = 2'($urandom_range(0, 3));
      adma_len_mismatch_in = 1'($urandom_range(0, 1));
      dma_sys_addr_in      = {32'($urandom), 32'($urandom)};
      host_addr_wr         = ($urandom_range(0, 7) == 0);
      host_addr_wdata      = {32'($urandom), 32'($urandom)};
      status_clr           = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      sig_en               = 4'($urandom_range(0, 15));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
